// File: rtl/colparity_theta.sv
// colparity_theta: buffers LANE_W 25-bit slices, then streams them back out
// with the optional column-parity (theta) mix applied per slice.
// Optional build macro COLPARITY_PARITY_OUT_EN adds the parityOut tap.
module colparity_theta #(
  parameter int unsigned LANE_W = 64,
  parameter int unsigned CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        thetaEn,
  input  logic [24:0] matrixIn,
  input  logic        inValid,
  input  logic        outAck,
  output logic        ready,
  output logic        putInput,
  output logic        outReady,
  output logic [24:0] matrixOut
`ifdef COLPARITY_PARITY_OUT_EN
  ,
  output logic [4:0]  parityOut
`endif
);

  localparam int unsigned SLICE_W = 25;
  localparam int unsigned PAR_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Column parity of one slice: bit x is XOR over y of bit 5*y+x.
  function automatic logic [PAR_W-1:0] slice_parity(input logic [SLICE_W-1:0] s);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        p[x] = p[x] ^ s[5*y+x];
      end
    end
    return p;
  endfunction

  // Theta mix of one slice given its own parity and the previous slice's parity.
  function automatic logic [SLICE_W-1:0] theta_mix(input logic [SLICE_W-1:0] s,
                                                   input logic [PAR_W-1:0]   pz,
                                                   input logic [PAR_W-1:0]   pzm1);
    logic [SLICE_W-1:0] o;
    o = s;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        o[5*y+x] = s[5*y+x] ^ pz[(x+4)%5] ^ pzm1[(x+1)%5];
      end
    end
    return o;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_slice_cnt;
  logic [CNT_W-1:0]     r_out_cnt;
  logic                 r_theta_en;
  logic                 r_ready;
  logic                 r_put_input;
  logic                 r_out_ready;
  logic [SLICE_W-1:0]   r_matrix_out;

  logic [SLICE_W-1:0]   r_buf [LANE_W];
  logic [PAR_W-1:0]     r_par [LANE_W];

  logic                 w_load_wr;
  logic                 w_out_adv;
  logic [PAR_W-1:0]     w_in_par;
  logic [CNT_W-1:0]     w_emit_idx;
  logic [SLICE_W-1:0]   w_emit_slice;
  logic [PAR_W-1:0]     w_emit_pz;
  logic [PAR_W-1:0]     w_emit_pzm1;
  logic [SLICE_W-1:0]   w_out_nxt;

  assign w_in_par = slice_parity(matrixIn);

  // Next-state decode and load/emit strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_wr   = 1'b0;
    w_out_adv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (inValid) begin
          w_load_wr = 1'b1;
          if (r_slice_cnt == CNT_W'(LANE_W-1)) w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (outAck) begin
          w_out_adv = 1'b1;
          if (r_out_cnt == CNT_W'(LANE_W-1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slice to present after this edge; on the LOAD->EMIT edge the last slice's
  // parity is not stored yet, so it is taken straight from the input.
  always_comb begin
    w_emit_idx   = w_out_adv ? (r_out_cnt + CNT_W'(1)) : r_out_cnt;
    w_emit_slice = r_buf[w_emit_idx];
    w_emit_pz    = r_par[w_emit_idx];
    w_emit_pzm1  = (r_state == LOAD) ? w_in_par : r_par[w_emit_idx - CNT_W'(1)];
    w_out_nxt    = '0;
    if (w_state_nxt == EMIT) begin
      w_out_nxt = r_theta_en ? theta_mix(w_emit_slice, w_emit_pz, w_emit_pzm1)
                             : w_emit_slice;
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_slice_cnt  <= '0;
      r_out_cnt    <= '0;
      r_theta_en   <= 1'b0;
      r_ready      <= 1'b1;
      r_put_input  <= 1'b0;
      r_out_ready  <= 1'b0;
      r_matrix_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) r_theta_en <= thetaEn;
      if (w_load_wr) r_slice_cnt <= r_slice_cnt + CNT_W'(1);
      if (w_out_adv) r_out_cnt <= r_out_cnt + CNT_W'(1);
      r_ready      <= (w_state_nxt == IDLE);
      r_put_input  <= (w_state_nxt == LOAD);
      r_out_ready  <= (w_state_nxt == EMIT);
      r_matrix_out <= w_out_nxt;
    end
  end

  // Slice buffer and per-slice parity; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (w_load_wr) begin
      r_buf[r_slice_cnt] <= matrixIn;
      r_par[r_slice_cnt] <= w_in_par;
    end
  end

  assign ready     = r_ready;
  assign putInput  = r_put_input;
  assign outReady  = r_out_ready;
  assign matrixOut = r_matrix_out;

`ifdef COLPARITY_PARITY_OUT_EN
  logic [PAR_W-1:0] r_parity_out;

  // Column parity of the slice currently on matrixOut.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity_out <= '0;
    end else begin
      r_parity_out <= (w_state_nxt == EMIT) ? w_emit_pz : '0;
    end
  end

  assign parityOut = r_parity_out;
`else
  // Parity tap not built; slice outputs are identical either way.
`endif

endmodule

// File: tb/tb_colparity_theta.sv
// Scoreboard bench for colparity_theta: expected slices are queued from a
// reference model when a state is loaded and compared as the DUT emits them.
module tb_colparity_theta;

  localparam int unsigned LANE_W = 64;
  localparam int unsigned CNT_W  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        thetaEn;
  logic [24:0] matrixIn;
  logic        inValid;
  logic        outAck;
  logic        ready;
  logic        putInput;
  logic        outReady;
  logic [24:0] matrixOut;
`ifdef COLPARITY_PARITY_OUT_EN
  logic [4:0]  parityOut;
`endif

  colparity_theta #(.LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .thetaEn   (thetaEn),
    .matrixIn  (matrixIn),
    .inValid   (inValid),
    .outAck    (outAck),
    .ready     (ready),
    .putInput  (putInput),
    .outReady  (outReady),
    .matrixOut (matrixOut)
`ifdef COLPARITY_PARITY_OUT_EN
    ,
    .parityOut (parityOut)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_pop  = 0;
  logic [24:0] exp_q [$];
  logic [24:0] slices [LANE_W];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference theta over the whole state held in slices[].
  task automatic push_expected(input bit th);
    logic [4:0]  p [LANE_W];
    logic [24:0] o;
    for (int z = 0; z < LANE_W; z++) begin
      for (int x = 0; x < 5; x++) begin
        p[z][x] = slices[z][x] ^ slices[z][x+5] ^ slices[z][x+10] ^
                  slices[z][x+15] ^ slices[z][x+20];
      end
    end
    for (int z = 0; z < LANE_W; z++) begin
      o = slices[z];
      if (th) begin
        for (int y = 0; y < 5; y++) begin
          for (int x = 0; x < 5; x++) begin
            o[5*y+x] = slices[z][5*y+x] ^ p[z][(x+4)%5] ^
                       p[(z+LANE_W-1)%LANE_W][(x+1)%5];
          end
        end
      end
      exp_q.push_back(o);
    end
  endtask

  // Output monitor: compares every presented slice, pops on acknowledge.
  always @(negedge clk) begin
    check_eq("onehot", 32'(ready) + 32'(putInput) + 32'(outReady), 32'd1);
    if (outReady) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'(outReady), 32'd0);
      end else begin
        check_eq($sformatf("slice%0d", n_pop), 32'(matrixOut), 32'(exp_q[0]));
        if (outAck) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end else begin
      check_eq("idle_zero", 32'(matrixOut), 32'd0);
    end
  end

  task automatic do_start(input bit th);
    @(posedge clk); #1;
    start   = 1'b1;
    thetaEn = th;
    @(posedge clk); #1;
    start   = 1'b0;
    check_eq("load_entry", 32'(putInput), 32'd1);
  endtask

  // Feeds n slices; start/thetaEn are toggled meanwhile and must be ignored.
  task automatic load_slices(input int n, input int gap, input bit th);
    for (int z = 0; z < n; z++) begin
      inValid  = 1'b1;
      matrixIn = slices[z];
      start    = 1'b1;
      thetaEn  = ~th;
      @(posedge clk); #1;
      for (int g = 0; g < gap; g++) begin
        inValid  = 1'b0;
        matrixIn = 25'($urandom);
        @(posedge clk); #1;
      end
    end
    inValid = 1'b0;
    start   = 1'b0;
    thetaEn = th;
  endtask

  task automatic drain(input int stall_at);
    int stall_left;
    stall_left = 3;
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      if (stall_at >= 0 && n_pop == stall_at && stall_left > 0) begin
        outAck = 1'b0;
        stall_left--;
      end else begin
        outAck = 1'b1;
      end
    end
    outAck = 1'b1;
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    check_eq("ready_after", 32'(ready), 32'd1);
    check_eq("outready_after", 32'(outReady), 32'd0);
  endtask

  task automatic run_op(input bit th, input int gap, input int stall_at);
    n_pop  = 0;
    outAck = 1'b1;
    push_expected(th);
    do_start(th);
    load_slices(LANE_W, gap, th);
    drain(stall_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    thetaEn  = 1'b0;
    matrixIn = '0;
    inValid  = 1'b0;
    outAck   = 1'b1;
    #12;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_put", 32'(putInput), 32'd0);
    check_eq("rst_outrdy", 32'(outReady), 32'd0);
    check_eq("rst_mout", 32'(matrixOut), 32'd0);
    #5 rst = 1'b1;

    // All-zero state with theta
    for (int z = 0; z < LANE_W; z++) slices[z] = '0;
    run_op(1'b1, 0, -1);

    // Single bit in slice 0
    for (int z = 0; z < LANE_W; z++) slices[z] = '0;
    slices[0] = 25'h0000001;
    push_expected(1'b1);
    check_eq("model_s0", 32'(exp_q[0]), 32'h0210843);
    check_eq("model_s1", 32'(exp_q[1]), 32'h1084210);
    exp_q.delete();
    run_op(1'b1, 0, -1);

    // Single bit in slice 63: wrap-around into slice 0
    for (int z = 0; z < LANE_W; z++) slices[z] = '0;
    slices[LANE_W-1] = 25'h0000001;
    push_expected(1'b1);
    check_eq("model_s63", 32'(exp_q[LANE_W-1]), 32'h0210843);
    check_eq("model_wrap", 32'(exp_q[0]), 32'h1084210);
    exp_q.delete();
    run_op(1'b1, 0, -1);

    // Random pass-through with input gaps
    for (int z = 0; z < LANE_W; z++) slices[z] = 25'($urandom);
    run_op(1'b0, 2, -1);

    // Random theta with backpressure at slice 5
    for (int z = 0; z < LANE_W; z++) slices[z] = 25'($urandom);
    run_op(1'b1, 0, 5);

    // Reset part-way through a load
    for (int z = 0; z < LANE_W; z++) slices[z] = 25'($urandom);
    n_pop = 0;
    do_start(1'b1);
    load_slices(10, 0, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_put", 32'(putInput), 32'd0);
    check_eq("abort_outrdy", 32'(outReady), 32'd0);
    #13 rst = 1'b1;

    // Fresh operation after the abort
    for (int z = 0; z < LANE_W; z++) slices[z] = 25'($urandom);
    run_op(1'b1, 1, -1);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/colparity_theta.md
COLPARITY_THETA -- requirements
Module: colparity_theta

Interface
REQ-001 Parameter LANE_W, default 64, meaning: number of 25-bit slices per state (power of two, 8..64).
REQ-002 Parameter CNT_W, default 6, meaning: slice-counter width, equal to log2(LANE_W).
REQ-003 clk  input  1  meaning: single clock; all state updates on its rising edge.
REQ-004 rst  input  1  meaning: asynchronous, active-low reset.
REQ-005 start  input  1  meaning: one-cycle request to begin a new state; sampled in IDLE only.
REQ-006 thetaEn  input  1  meaning: 1 = apply column-parity (theta) mix; 0 = pass-through; sampled with start.
REQ-007 matrixIn  input  25  meaning: one input slice; bit index 5*y+x, x,y in 0..4.
REQ-008 inValid  input  1  meaning: matrixIn holds a valid slice this cycle.
REQ-009 outAck  input  1  meaning: consumer accepts the current matrixOut slice this cycle.
REQ-010 ready  output  1  meaning: block idle and able to accept start.
REQ-011 putInput  output  1  meaning: block requests and accepts input slices.
REQ-012 outReady  output  1  meaning: matrixOut holds a valid output slice.
REQ-013 matrixOut  output  25  meaning: one output slice, same bit order as matrixIn.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, EMIT; ready=1 only in IDLE, putInput=1 only in LOAD, outReady=1 only in EMIT.
REQ-015 IDLE->LOAD on start=1; start in LOAD or EMIT SHALL be ignored.
REQ-016 In LOAD, each cycle with inValid=1 SHALL write matrixIn to slice buffer entry sliceCnt and increment sliceCnt; inValid=0 cycles SHALL leave state unchanged.
REQ-017 LOAD->EMIT on the edge capturing slice LANE_W-1; sliceCnt SHALL wrap to 0.
REQ-018 Parity P[x][z] SHALL be the XOR over y of slice z bits x+5y.
REQ-019 With thetaEn=1, out bit (x,y,z) SHALL equal in(x,y,z) XOR P[(x+4) mod 5][z] XOR P[(x+1) mod 5][(z-1) mod LANE_W].
REQ-020 Slice 0 SHALL use slice LANE_W-1 parity as its z-1 term (wrap-around).
REQ-021 With thetaEn=0, matrixOut SHALL equal the stored input slice unchanged.
REQ-022 In EMIT, matrixOut SHALL present slice outCnt, starting at 0 in the first EMIT cycle; outCnt SHALL advance only on outAck=1.
REQ-023 With outAck=0, matrixOut and outCnt SHALL hold (backpressure).
REQ-024 EMIT->IDLE on the edge acknowledging slice LANE_W-1; ready=1 the next cycle.
REQ-025 Minimum latency: LANE_W cycles load, LANE_W cycles emit, no idle cycle between.
REQ-026 matrixOut SHALL be 0 when outReady=0.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, sliceCnt=0, outCnt=0, latched thetaEn=0, ready=1, putInput=0, outReady=0, matrixOut=0.
REQ-028 Reset mid-LOAD or mid-EMIT SHALL abandon the state; buffer contents are undefined and not cleared.
REQ-029 First start after reset release SHALL behave as a fresh operation.

Configuration
REQ-030 Macro COLPARITY_PARITY_OUT_EN defined: extra output parityOut (5 bits) SHALL carry P[x][outCnt] for x=0..4 in EMIT, 0 otherwise.
REQ-031 Macro undefined: parityOut port SHALL be absent; all other behaviour identical.

Verification (LANE_W=64, outAck=1 unless stated)
REQ-032 All-zero state, thetaEn=1 -> 64 slices of 0x0000000, ready=1 one cycle after last ack.
REQ-033 Slice 0 = 0x0000001, others 0, thetaEn=1 -> out slice 0 = 0x0210843, slice 1 = 0x1084210, rest 0.
REQ-034 Slice 63 = 0x0000001, others 0, thetaEn=1 -> out slice 63 = 0x0210843, slice 0 = 0x1084210 (wrap).
REQ-035 Random slices, thetaEn=0 -> output sequence equals input; inValid gaps of 2 cycles do not alter result.
REQ-036 outAck=0 for 3 cycles at slice 5 -> matrixOut holds slice 5 value, outCnt=5, then resumes with slice 6.
REQ-037 rst=0 after 10 slices loaded -> ready=1, putInput=0 immediately; new start then loads from slice 0.
